// File: rtl/gfp8_dot_sequencer.sv
// Command/group sequencer for a GFP8 dot product: feeds group operands to an external
// 1-cycle group-dot unit and folds its results into a saturating GFP accumulator.
module gfp8_dot_sequencer #(
    parameter int NG_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [NG_W-1:0]   i_cmd_ngroups,
    input  logic              i_grp_valid,
    output logic              o_grp_ready,
    input  logic [7:0]        i_grp_exp_left,
    input  logic [7:0]        i_grp_exp_right,
    input  logic [255:0]      i_grp_man_left,
    input  logic [255:0]      i_grp_man_right,
    output logic [7:0]        o_dot_exp_left,
    output logic [7:0]        o_dot_exp_right,
    output logic [255:0]      o_dot_man_left,
    output logic [255:0]      o_dot_man_right,
    input  logic [31:0]       i_dot_mantissa,
    input  logic [7:0]        i_dot_exponent,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [31:0]       o_res_mantissa,
    output logic [7:0]        o_res_exponent,
    output logic              o_busy,
    output logic [NG_W-1:0]   o_grp_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NG_W-1:0]    ngroups_q;
    logic [NG_W-1:0]    grp_count_q;
    logic [1:0]         issue_q;
    logic               first_q;
    logic signed [31:0] acc_man_q;
    logic signed [7:0]  acc_exp_q;

    logic               cmd_fire;
    logic               grp_ready;
    logic               grp_fire;
    logic               last_grp;
    logic signed [31:0] dot_man;
    logic signed [7:0]  dot_exp;
    logic signed [8:0]  exp_diff;
    logic [8:0]         shift_amt;
    logic signed [31:0] add_a;
    logic signed [31:0] add_b;
    logic [32:0]        sum;
    logic signed [31:0] acc_man_nxt;
    logic signed [7:0]  acc_exp_nxt;

    // Arithmetic shift where any distance of 31 or more collapses to the sign fill.
    function automatic logic signed [31:0] asr_fill(input logic signed [31:0] x,
                                                    input logic [8:0] sh);
        if (sh >= 9'd31) begin
            return {32{x[31]}};
        end
        return x >>> sh[4:0];
    endfunction

    assign cmd_fire  = i_cmd_valid && (state == IDLE);
    assign grp_ready = (state == RUN) && (grp_count_q < ngroups_q);
    assign grp_fire  = i_grp_valid && grp_ready;
    assign last_grp  = grp_fire && (grp_count_q == ngroups_q - 1'b1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (i_cmd_valid) state_nxt = (i_cmd_ngroups == '0) ? DONE : RUN;
            RUN:   if (last_grp) state_nxt = DRAIN;
            // last result lands while nothing newer is still one stage behind it
            DRAIN: if (issue_q[1] && !issue_q[0]) state_nxt = DONE;
            DONE:  if (i_res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign dot_man = i_dot_mantissa;
    assign dot_exp = i_dot_exponent;

    always_comb begin
        exp_diff    = {dot_exp[7], dot_exp} - {acc_exp_q[7], acc_exp_q};
        add_a       = acc_man_q;
        add_b       = dot_man;
        acc_exp_nxt = acc_exp_q;
        shift_amt   = '0;
        if (exp_diff > 9'sd0) begin
            shift_amt   = exp_diff;
            add_a       = asr_fill(acc_man_q, shift_amt);
            acc_exp_nxt = dot_exp;
        end else begin
            shift_amt   = -exp_diff;
            add_b       = asr_fill(dot_man, shift_amt);
        end
        sum = {add_a[31], add_a} + {add_b[31], add_b};
        if (sum[32] != sum[31]) begin
            acc_man_nxt = sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end else begin
            acc_man_nxt = sum[31:0];
        end
        if (first_q) begin
            acc_man_nxt = dot_man;
            acc_exp_nxt = dot_exp;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= IDLE;
            ngroups_q       <= '0;
            grp_count_q     <= '0;
            issue_q         <= '0;
            first_q         <= 1'b0;
            acc_man_q       <= '0;
            acc_exp_q       <= '0;
            o_dot_exp_left  <= '0;
            o_dot_exp_right <= '0;
            o_dot_man_left  <= '0;
            o_dot_man_right <= '0;
        end else begin
            state   <= state_nxt;
            issue_q <= {issue_q[0], grp_fire};
            if (cmd_fire) begin
                ngroups_q   <= i_cmd_ngroups;
                grp_count_q <= '0;
                acc_man_q   <= '0;
                acc_exp_q   <= '0;
                first_q     <= 1'b1;
            end
            if (grp_fire) begin
                grp_count_q     <= grp_count_q + 1'b1;
                o_dot_exp_left  <= i_grp_exp_left;
                o_dot_exp_right <= i_grp_exp_right;
                o_dot_man_left  <= i_grp_man_left;
                o_dot_man_right <= i_grp_man_right;
            end
            if (issue_q[1]) begin
                acc_man_q <= acc_man_nxt;
                acc_exp_q <= acc_exp_nxt;
                first_q   <= 1'b0;
            end
        end
    end

    assign o_cmd_ready    = (state == IDLE);
    assign o_busy         = (state != IDLE);
    assign o_res_valid    = (state == DONE);
    assign o_grp_ready    = grp_ready;
    assign o_grp_count    = grp_count_q;
    assign o_res_mantissa = acc_man_q;
    assign o_res_exponent = acc_exp_q;

endmodule
